// File: rtl/l1_cache_ctrl.sv
// L1 data-cache sequencing controller: zero-wait hits, load-miss fetch and fill,
// write-through / no-write-allocate stores, pipeline stall and hit/miss counters.
module l1_cache_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            byte_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  ready_o,
    output logic                  stall_o,
    output logic                  cache_lookup_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rd_data_i,
    output logic                  cache_wr_en_o,
    output logic                  cache_fill_o,
    output logic [DATA_WIDTH-1:0] cache_fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_byte_en_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS_RD = 2'd1,
        FILL    = 2'd2,
        WR_MEM  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic [31:0]           r_hit_cnt;
    logic [31:0]           r_miss_cnt;
    logic                  w_be_legal;
    logic                  w_accept;

    // Zero-extend the selected lane; unknown enable codes return zero.
    function automatic logic [DATA_WIDTH-1:0] fmt_rd(input logic [BE_W-1:0] be,
                                                     input logic [DATA_WIDTH-1:0] w);
        case (be)
            4'b0001: fmt_rd = DATA_WIDTH'(w[7:0]);
            4'b0011: fmt_rd = DATA_WIDTH'(w[15:0]);
            4'b1111: fmt_rd = w;
            default: fmt_rd = '0;
        endcase
    endfunction

    assign w_be_legal = (byte_en_i == 4'b0001) || (byte_en_i == 4'b0011) ||
                        (byte_en_i == 4'b1111);
    assign w_accept   = (r_state == IDLE) && req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_fill_data <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= addr_i;
                r_wdata <= wr_data_i;
                r_be    <= byte_en_i;
                if (cache_hit_i) r_hit_cnt  <= r_hit_cnt + 32'd1;
                else             r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if ((r_state == MISS_RD) && mem_ack_i) r_fill_data <= mem_rdata_i;
        end
    end

    always_comb begin
        w_next            = r_state;
        ready_o           = 1'b0;
        rd_data_o         = '0;
        cache_lookup_o    = 1'b0;
        cache_wr_en_o     = 1'b0;
        cache_fill_o      = 1'b0;
        cache_fill_data_o = '0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    cache_lookup_o = 1'b1;
                    if (wr_en_i) begin
                        cache_wr_en_o = cache_hit_i && w_be_legal;
                        w_next        = WR_MEM;
                    end else if (cache_hit_i) begin
                        ready_o   = 1'b1;
                        rd_data_o = fmt_rd(byte_en_i, cache_rd_data_i);
                    end else begin
                        w_next = MISS_RD;
                    end
                end
            end
            MISS_RD: begin
                if (mem_ack_i) w_next = FILL;
            end
            FILL: begin
                cache_fill_o      = 1'b1;
                cache_fill_data_o = r_fill_data;
                ready_o           = 1'b1;
                rd_data_o         = fmt_rd(r_be, r_fill_data);
                w_next            = IDLE;
            end
            WR_MEM: begin
                if (mem_ack_i) begin
                    ready_o = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Reset wins: no strobe or completion may escape in the reset cycle.
        if (rst) begin
            w_next            = IDLE;
            ready_o           = 1'b0;
            rd_data_o         = '0;
            cache_lookup_o    = 1'b0;
            cache_wr_en_o     = 1'b0;
            cache_fill_o      = 1'b0;
            cache_fill_data_o = '0;
        end
    end

    assign stall_o       = req_i & ~ready_o;
    assign mem_req_o     = (r_state == MISS_RD) || (r_state == WR_MEM);
    assign mem_we_o      = (r_state == WR_MEM);
    assign mem_addr_o    = mem_req_o ? r_addr : '0;
    assign mem_wdata_o   = mem_we_o ? r_wdata : '0;
    assign mem_byte_en_o = (r_state == MISS_RD) ? 4'b1111 :
                           (r_state == WR_MEM)  ? r_be    : 4'b0000;
    assign hit_cnt_o     = r_hit_cnt;
    assign miss_cnt_o    = r_miss_cnt;

endmodule
